// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the
// data-memory block and its load path.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic logic misaligned(
    input size_e    sz,
    input logic [1:0] lane
  );
    logic bad;
    bad = 1'b1;
    unique case (1'b1)
      sz == SZ_BYTE: bad = 1'b0;
      sz == SZ_HALF: bad = lane[0];
      sz == SZ_WORD: bad = |lane;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(
    input size_e    sz,
    input logic [1:0] lane
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      sz == SZ_BYTE: be = 4'b0001 << lane;
      sz == SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      sz == SZ_WORD: be = 4'b1111;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension.
// Purely combinational.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsgn,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;
  size_e       sz;

  assign sz = size_e'(size);

  always_comb begin
    b = 8'h00;
    unique case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
  end

  assign h = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = '0;
    unique case (1'b1)
      sz == SZ_BYTE:
        result = {{24{~unsgn & b[7]}}, b};
      sz == SZ_HALF:
        result = {{16{~unsgn & h[15]}}, h};
      sz == SZ_WORD:
        result = word;
      default:
        result = '0;
    endcase
  end

endmodule

// File: rtl/dm_param.sv
// Byte-addressable data memory with
// optional zero-fill after reset.
module dm_param
  import dm_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic              busy,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              fault
);

  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 1 << IW;

  state_e        state, state_nx;
  logic [IW-1:0] cnt, cnt_nx;

  logic [31:0]   mem [DEPTH];

  size_e         sz;
  logic [1:0]    lane;
  logic          acc, bad;
  logic          st_ok, ld_ok;

  logic          mem_we;
  logic [3:0]    mem_be;
  logic [IW-1:0] mem_idx;
  logic [31:0]   mem_wd;
  logic [31:0]   rword, ext;

  assign busy = (state == ST_INIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_ZERO ? ST_INIT : ST_READY;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_INIT: begin
        cnt_nx = cnt + 1'b1;
        if (&cnt) state_nx = ST_READY;
      end
      default: state_nx = ST_READY;
    endcase
  end

  assign sz    = size_e'(req_size);
  assign lane  = addr[1:0];
  assign acc   = req_valid & ~busy;
  assign bad   = misaligned(sz, lane);
  assign st_ok = acc & req_we & ~bad;
  assign ld_ok = acc & ~req_we & ~bad;

  // Fill owns the single port while busy.
  always_comb begin
    mem_we  = 1'b0;
    mem_be  = 4'b0000;
    mem_idx = addr[ADDR_W-1:2];
    mem_wd  = '0;
    if (busy) begin
      mem_we  = ~rst;
      mem_be  = 4'b1111;
      mem_idx = cnt;
    end else begin
      mem_we = st_ok & ~rst;
      mem_be = lane_be(sz, lane);
      unique case (1'b1)
        sz == SZ_BYTE: mem_wd = {4{din[7:0]}};
        sz == SZ_HALF: mem_wd = {2{din[15:0]}};
        default:       mem_wd = din;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) begin
          mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
        end
      end
    end
  end

  assign rword = mem[mem_idx];

  dm_load_ext u_ext (
    .word   (rword),
    .lane   (lane),
    .size   (req_size),
    .unsgn  (req_unsigned),
    .result (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      fault  <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= ld_ok;
      fault  <= acc & bad;
      if (ld_ok) rdata <= ext;
    end
  end

endmodule

// File: tb/tb_dm_param.sv
// Scoreboard bench for dm_param: directed
// vectors, monitor pops on rvalid/fault.
module tb_dm_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] din = '0;
  logic        busy;
  logic [31:0] rdata;
  logic        rvalid;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_fault;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  dm_param #(.ADDR_W(12), .INIT_ZERO(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .addr         (addr),
    .din          (din),
    .busy         (busy),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .fault        (fault)
  );

  always @(negedge clk) begin
    if (rvalid || fault) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out rvalid=%0b fault=%0b rdata=%08h",
                 rvalid, fault, rdata);
      end else begin
        exp_t e;
        bit ok;
        e = sbq.pop_front();
        if (e.is_fault) ok = fault && !rvalid;
        else ok = rvalid && !fault && (rdata == e.data);
        if (!ok) begin
          errors++;
          $display("FAIL %s got rvalid=%0b fault=%0b rdata=%08h want fault=%0b rdata=%08h",
                   e.name, rvalid, fault, rdata, e.is_fault, e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic u, input logic [11:0] a,
                       input logic [31:0] d);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = u;
    addr         = a;
    din          = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_load(input string nm, input logic [31:0] d);
    exp_t e;
    e.is_fault = 1'b0;
    e.data     = d;
    e.name     = nm;
    sbq.push_back(e);
  endtask

  task automatic expect_fault(input string nm);
    exp_t e;
    e.is_fault = 1'b1;
    e.data     = '0;
    e.name     = nm;
    sbq.push_back(e);
  endtask

  task automatic load(input string nm, input logic [1:0] sz,
                      input logic u, input logic [11:0] a,
                      input logic [31:0] d);
    expect_load(nm, d);
    issue(1'b0, sz, u, a, 32'h0);
  endtask

  task automatic store(input logic [1:0] sz, input logic [11:0] a,
                       input logic [31:0] d);
    issue(1'b1, sz, 1'b0, a, d);
  endtask

  // Counts busy cycles; at cycle inj a store then a load hit while busy.
  task automatic count_busy(input string nm, input int inj);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      if (n == inj) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        addr      = 12'h000;
        din       = 32'h12345678;
      end else if (n == inj + 1) begin
        req_we    = 1'b0;
      end else begin
        req_valid = 1'b0;
      end
      n++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk(nm, n, 1024);
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 1);
    chk("rst_rvalid", {31'b0, rvalid}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_rdata", rdata, 0);
    count_busy("fill_len", -10);

    load("lw_ffc", 2'b10, 1'b0, 12'hFFC, 32'h0);

    store(2'b10, 12'h010, 32'h11223344);
    store(2'b00, 12'h012, 32'h000000AB);
    load("lanes_sb", 2'b10, 1'b0, 12'h010, 32'h11AB3344);

    store(2'b10, 12'h020, 32'h80F07F01);
    load("lb_023", 2'b00, 1'b0, 12'h023, 32'hFFFFFF80);
    load("lbu_023", 2'b00, 1'b1, 12'h023, 32'h00000080);
    load("lh_020", 2'b01, 1'b0, 12'h020, 32'h00007F01);
    load("lh_022", 2'b01, 1'b0, 12'h022, 32'hFFFF80F0);
    load("lhu_022", 2'b01, 1'b1, 12'h022, 32'h000080F0);
    load("lb_021", 2'b00, 1'b0, 12'h021, 32'h0000007F);
    load("lw_u_020", 2'b10, 1'b1, 12'h020, 32'h80F07F01);

    store(2'b10, 12'h030, 32'h55667788);
    expect_fault("flt_sh031");
    store(2'b01, 12'h031, 32'h0000FFFF);
    expect_fault("flt_lw032");
    issue(1'b0, 2'b10, 1'b0, 12'h032, 32'h0);
    expect_fault("flt_sz11");
    store(2'b11, 12'h030, 32'hFFFFFFFF);
    load("flt_unchg", 2'b10, 1'b0, 12'h030, 32'h55667788);
    store(2'b01, 12'h032, 32'h0000CAFE);
    load("sh_032", 2'b10, 1'b0, 12'h030, 32'hCAFE7788);

    store(2'b10, 12'h040, 32'hDEADBEEF);
    load("b2b", 2'b10, 1'b0, 12'h040, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("hold_rdata", rdata, 32'hDEADBEEF);
    chk("hold_rvalid", {31'b0, rvalid}, 0);

    store(2'b10, 12'h000, 32'hA5A5A5A5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (500) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy", {31'b0, busy}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_busy("refill_len", 10);
    load("drop_st", 2'b10, 1'b0, 12'h000, 32'h0);
    load("refill_040", 2'b10, 1'b0, 12'h040, 32'h0);

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
